// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI4-lite word SRAM responder with fixed or LFSR-randomised response latency
module axi_lite_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RAND_DELAY  = 1,
    parameter int          FIXED_DELAY = 0,
    parameter int          DELAY_BITS  = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic [2:0]  arsize,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = DELAY_BITS > 3 ? DELAY_BITS : 3;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} w_state_t;
    r_state_t rs, rs_n;
    w_state_t ws, ws_n;
    logic [7:0] lfsr;
    logic [CW-1:0] d, rcnt, wcnt;
    logic [31:0] ra, wa, wd, roff, woff;
    logic [2:0] rsz;
    logic [3:0] wst;
    logic aw_got, w_got, ar_hs, aw_hs, w_hs, both, r_in, w_in, r_bad, w_commit;
    logic [1:0] rresp_c;
    logic [31:0] mem [DEPTH_WORDS];
    assign d = RAND_DELAY != 0 ? CW'(lfsr[DELAY_BITS-1:0]) : CW'(FIXED_DELAY);
    assign roff = ra - ADDR_BASE;
    assign woff = wa - ADDR_BASE;
    assign r_in = ra >= ADDR_BASE && roff < SPAN;
    assign w_in = wa >= ADDR_BASE && woff < SPAN;
    assign r_bad = rsz > 3'd2 || (rsz == 3'd1 && ra[0]) || (rsz == 3'd2 && ra[1:0] != 2'b00);
    assign rresp_c = !r_in ? 2'b11 : r_bad ? 2'b10 : 2'b00;
    assign w_commit = rst && ws == W_WAIT && wcnt == '0 && w_in;
    always_comb begin
        arready = rst && rs == R_IDLE;
        rvalid = rs == R_RESP;
        ar_hs = arvalid && arready;
        rs_n = ar_hs ? R_WAIT : (rs == R_WAIT && rcnt == '0) ? R_RESP : (rs == R_RESP && rready) ? R_IDLE : rs;
    end
    always_comb begin
        awready = rst && ws == W_COLLECT && !aw_got;
        wready = rst && ws == W_COLLECT && !w_got;
        bvalid = ws == W_RESP;
        aw_hs = awvalid && awready;
        w_hs = wvalid && wready;
        both = (aw_got || aw_hs) && (w_got || w_hs);
        ws_n = (ws == W_COLLECT && both) ? W_WAIT : (ws == W_WAIT && wcnt == '0) ? W_RESP : (ws == W_RESP && bready) ? W_COLLECT : ws;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            rs <= R_IDLE;
            ws <= W_COLLECT;
            aw_got <= 1'b0;
            w_got <= 1'b0;
            lfsr <= LFSR_SEED;
            rcnt <= '0;
            wcnt <= '0;
            rdata <= '0;
            rresp <= '0;
            bresp <= '0;
        end else begin
            rs <= rs_n;
            ws <= ws_n;
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            rcnt <= ar_hs ? d : (rs == R_WAIT && rcnt != '0) ? rcnt - 1'b1 : rcnt;
            wcnt <= (ws == W_COLLECT && both) ? d : (ws == W_WAIT && wcnt != '0) ? wcnt - 1'b1 : wcnt;
            if (ar_hs) begin
                ra <= araddr;
                rsz <= arsize;
            end
            if (rs == R_WAIT && rcnt == '0) begin
                rresp <= rresp_c;
                rdata <= rresp_c == 2'b00 ? mem[roff[IW+1:2]] : '0;
            end
            if (aw_hs) begin
                wa <= awaddr;
                aw_got <= 1'b1;
            end
            if (w_hs) begin
                wd <= wdata;
                wst <= wstrb;
                w_got <= 1'b1;
            end
            if (ws == W_WAIT && wcnt == '0)
                bresp <= (wst == 4'b0000 || w_in) ? 2'b00 : 2'b11;
            if (ws == W_RESP && bready) begin
                aw_got <= 1'b0;
                w_got <= 1'b0;
            end
        end
    end
    // Array has no reset; a write lands only on the edge that enters W_RESP
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (w_commit && wst[i])
                mem[woff[IW+1:2]][8*i +: 8] <= wd[8*i +: 8];
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb_axi_lite_sram_slave: directed vectors and LFSR-timed random traffic against three parameterisations
module tb_axi_lite_sram_slave;
    localparam logic [31:0] BASE = 32'h8000_0000;
    logic clk = 0, rst = 0;
    logic [31:0] araddr [3], rdata [3], awaddr [3], wdata [3];
    logic [2:0] arsize [3];
    logic [1:0] rresp [3], bresp [3];
    logic [3:0] wstrb [3];
    logic arvalid [3], arready [3], rvalid [3], rready [3];
    logic awvalid [3], awready [3], wvalid [3], wready [3], bvalid [3], bready [3];
    int vectors = 0, miscompares = 0, kcnt = 0;

    // instance 0: no delay, 1: fixed delay 5, 2: LFSR delay
    for (genvar g = 0; g < 3; g++) begin : u
        axi_lite_sram_slave #(.RAND_DELAY(g == 2 ? 1 : 0), .FIXED_DELAY(g == 1 ? 5 : 0)) dut (
            .clk(clk), .rst(rst),
            .araddr(araddr[g]), .arvalid(arvalid[g]), .arready(arready[g]), .arsize(arsize[g]),
            .rdata(rdata[g]), .rresp(rresp[g]), .rvalid(rvalid[g]), .rready(rready[g]),
            .awaddr(awaddr[g]), .awvalid(awvalid[g]), .awready(awready[g]),
            .wdata(wdata[g]), .wstrb(wstrb[g]), .wvalid(wvalid[g]), .wready(wready[g]),
            .bresp(bresp[g]), .bvalid(bvalid[g]), .bready(bready[g]));
    end

    always #5 clk = ~clk;
    always @(posedge clk) kcnt <= rst ? kcnt + 1 : 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // LFSR value k cycles after reset: 8-bit Fibonacci, taps 8,6,5,4
    function automatic logic [7:0] lfsr_at(input int k);
        logic [7:0] l = 8'hA5;
        for (int n = 0; n < k; n++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1 rst = 1;
    endtask

    task automatic txn(input int i, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] d, input logic [3:0] st,
                       output logic [1:0] resp, output logic [31:0] data, output int dly, output int kh);
        bit hs = 0;
        resp = 2'bxx; data = 'x; dly = -1; kh = 0;
        @(posedge clk); #1;
        if (wr) begin
            awaddr[i] = a; wdata[i] = d; wstrb[i] = st; awvalid[i] = 1; wvalid[i] = 1; bready[i] = 1;
        end else begin
            araddr[i] = a; arsize[i] = sz; arvalid[i] = 1; rready[i] = 1;
        end
        for (int t = 0; t < 40 && !hs; t++) begin
            @(negedge clk);
            hs = wr ? (awready[i] && wready[i]) : arready[i];
        end
        kh = kcnt;
        @(posedge clk); #1;
        awvalid[i] = 0; wvalid[i] = 0; arvalid[i] = 0;
        if (hs)
            for (int c = 1; c < 40 && dly < 0; c++) begin
                @(negedge clk);
                if (wr ? bvalid[i] : rvalid[i]) begin
                    dly = c - 2;
                    resp = wr ? bresp[i] : rresp[i];
                    data = rdata[i];
                end
            end
        @(posedge clk); #1;
        rready[i] = 0; bready[i] = 0;
    endtask

    typedef struct {
        int inst; bit wr; logic [31:0] a; logic [2:0] sz; logic [31:0] d; logic [3:0] st;
        logic [1:0] er; logic [31:0] ed; int edly;
    } vec_t;
    typedef struct {bit wr; logic [31:0] a; logic [2:0] sz; logic [31:0] d; logic [3:0] st;} rtx_t;

    vec_t vt [17];
    rtx_t rl [216];
    logic [31:0] ref_mem [16];
    int dlog [2][216];

    initial begin
        logic [1:0] resp, er;
        logic [31:0] data, ed, off;
        logic [7:0] lv;
        int dly, kh, nd;
        bit inr, bad;
        for (int i = 0; i < 3; i++) begin
            araddr[i] = 0; arsize[i] = 0; arvalid[i] = 0; rready[i] = 0;
            awaddr[i] = 0; wdata[i] = 0; wstrb[i] = 0; awvalid[i] = 0; wvalid[i] = 0; bready[i] = 0;
        end
        vt[0]  = '{0, 1, 32'h8000_0010, 3'd2, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 0};
        vt[1]  = '{0, 0, 32'h8000_0010, 3'd2, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 0};
        vt[2]  = '{0, 1, 32'h8000_0000, 3'd2, 32'h11111111, 4'hF, 2'b00, 32'h0, 0};
        vt[3]  = '{0, 1, 32'h8000_3FFC, 3'd2, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0, 0};
        vt[4]  = '{0, 0, 32'h8000_3FFC, 3'd2, 32'h0, 4'h0, 2'b00, 32'hCAFEF00D, 0};
        vt[5]  = '{0, 0, 32'h7FFF_FFFC, 3'd2, 32'h0, 4'h0, 2'b11, 32'h0, 0};
        vt[6]  = '{0, 0, 32'h8000_4000, 3'd2, 32'h0, 4'h0, 2'b11, 32'h0, 0};
        vt[7]  = '{0, 1, 32'h8000_4000, 3'd2, 32'h12345678, 4'hF, 2'b11, 32'h0, 0};
        vt[8]  = '{0, 0, 32'h8000_0000, 3'd2, 32'h0, 4'h0, 2'b00, 32'h11111111, 0};
        vt[9]  = '{0, 0, 32'h8000_0001, 3'd1, 32'h0, 4'h0, 2'b10, 32'h0, 0};
        vt[10] = '{0, 0, 32'h8000_0002, 3'd1, 32'h0, 4'h0, 2'b00, 32'h11111111, 0};
        vt[11] = '{0, 0, 32'h8000_0011, 3'd0, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 0};
        vt[12] = '{0, 0, 32'h8000_0010, 3'd3, 32'h0, 4'h0, 2'b10, 32'h0, 0};
        vt[13] = '{0, 0, 32'h8000_0012, 3'd2, 32'h0, 4'h0, 2'b10, 32'h0, 0};
        vt[14] = '{0, 1, 32'h8000_0014, 3'd2, 32'h5A5A5A5A, 4'h0, 2'b00, 32'h0, 0};
        vt[15] = '{1, 1, 32'h8000_0020, 3'd2, 32'h0BADF00D, 4'hF, 2'b00, 32'h0, 5};
        vt[16] = '{1, 0, 32'h8000_0020, 3'd2, 32'h0, 4'h0, 2'b00, 32'h0BADF00D, 5};

        // reset state, readies forced low while rst is low
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_readies", {arready[i], awready[i], wready[i]}, 0);
            check("rst_valids", {rvalid[i], bvalid[i]}, 0);
            check("rst_regs", {rdata[i][27:0], rresp[i], bresp[i]}, 0);
        end
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check("idle_readies", {arready[i], awready[i], wready[i]}, 3'b111);

        foreach (vt[j]) begin
            txn(vt[j].inst, vt[j].wr, vt[j].a, vt[j].sz, vt[j].d, vt[j].st, resp, data, dly, kh);
            check($sformatf("vec%0d_resp", j), resp, vt[j].er);
            check($sformatf("vec%0d_delay", j), dly, vt[j].edly);
            if (!vt[j].wr) check($sformatf("vec%0d_data", j), data, vt[j].ed);
        end

        // read stalled by rready low for 4 cycles on fixed delay 5
        @(posedge clk); #1;
        araddr[1] = 32'h8000_0020; arsize[1] = 2; arvalid[1] = 1; rready[1] = 0;
        @(negedge clk);
        check("stall_arready", arready[1], 1);
        @(posedge clk); #1 arvalid[1] = 0;
        nd = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (arready[1] !== 0) nd++;
            if (c < 7 && rvalid[1] !== 0) nd++;
            if (c >= 7 && (rvalid[1] !== 1 || rdata[1] !== 32'h0BADF00D || rresp[1] !== 0)) nd++;
        end
        check("stall_hold_errs", nd, 0);
        @(posedge clk); #1 rready[1] = 1;
        @(negedge clk);
        check("stall_last", {rvalid[1], arready[1]}, 2'b10);
        @(posedge clk); #1 rready[1] = 0;
        @(negedge clk);
        check("stall_done", {rvalid[1], arready[1]}, 2'b01);

        // W three cycles ahead of AW, partial strobe
        @(posedge clk); #1;
        wdata[0] = 32'h0000_AA00; wstrb[0] = 4'b0010; wvalid[0] = 1; bready[0] = 1;
        @(negedge clk);
        check("wfirst_wready", wready[0], 1);
        @(posedge clk); #1 wvalid[0] = 0;
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (wready[0] !== 0 || bvalid[0] !== 0 || awready[0] !== 1) nd++;
            @(posedge clk); #1;
        end
        check("wfirst_wait_errs", nd, 0);
        awaddr[0] = 32'h8000_0010; awvalid[0] = 1;
        @(negedge clk);
        check("wfirst_awready", awready[0], 1);
        @(posedge clk); #1 awvalid[0] = 0;
        @(negedge clk);
        check("wfirst_b_early", bvalid[0], 0);
        @(negedge clk);
        check("wfirst_b", {bvalid[0], bresp[0]}, 3'b100);
        @(posedge clk); #1 bready[0] = 0;
        txn(0, 0, 32'h8000_0010, 2, 0, 0, resp, data, dly, kh);
        check("wfirst_readback", data, 32'hDEADAAEF);

        // read and write to one word reach their response states on the same edge
        txn(0, 1, 32'h8000_0030, 2, 32'h01020304, 4'hF, resp, data, dly, kh);
        @(posedge clk); #1;
        araddr[0] = 32'h8000_0030; arsize[0] = 2; arvalid[0] = 1; rready[0] = 1;
        awaddr[0] = 32'h8000_0030; wdata[0] = 32'hA0B0C0D0; wstrb[0] = 4'hF;
        awvalid[0] = 1; wvalid[0] = 1; bready[0] = 1;
        @(negedge clk);
        check("ovl_ready", {arready[0], awready[0], wready[0]}, 3'b111);
        @(posedge clk); #1 arvalid[0] = 0; awvalid[0] = 0; wvalid[0] = 0;
        @(negedge clk);
        @(negedge clk);
        check("ovl_valids", {rvalid[0], bvalid[0]}, 2'b11);
        check("ovl_old_data", rdata[0], 32'h01020304);
        @(posedge clk); #1 rready[0] = 0; bready[0] = 0;
        txn(0, 0, 32'h8000_0030, 2, 0, 0, resp, data, dly, kh);
        check("ovl_new_data", data, 32'hA0B0C0D0);

        // random traffic on the LFSR instance, replayed after a second reset
        for (int j = 0; j < 216; j++) begin
            int w, s;
            w = $urandom_range(0, 15);
            s = $urandom_range(0, 15);
            rl[j].wr = j < 16 ? 1 : ($urandom_range(0, 1) == 1);
            rl[j].a = j < 16 ? BASE + 32'(4 * j) : s == 0 ? BASE + 32'h4000 + 32'(4 * w) :
                      s == 1 ? BASE - 4 : BASE + 32'(4 * w) + $urandom_range(0, 3);
            rl[j].sz = 3'($urandom_range(0, 3));
            rl[j].d = $urandom;
            rl[j].st = j < 16 ? 4'hF : 4'($urandom_range(0, 15));
        end
        for (int p = 0; p < 2; p++) begin
            do_reset();
            for (int j = 0; j < 216; j++) begin
                txn(2, rl[j].wr, rl[j].a, rl[j].sz, rl[j].d, rl[j].st, resp, data, dly, kh);
                off = rl[j].a - BASE;
                inr = rl[j].a >= BASE && off < 32'h4000;
                bad = rl[j].sz > 2 || (rl[j].sz == 1 && off[0]) || (rl[j].sz == 2 && off[1:0] != 0);
                if (rl[j].wr) begin
                    er = (rl[j].st == 0 || inr) ? 2'b00 : 2'b11;
                    if (inr)
                        for (int b = 0; b < 4; b++)
                            if (rl[j].st[b]) ref_mem[off[5:2]][8*b +: 8] = rl[j].d[8*b +: 8];
                end else begin
                    er = !inr ? 2'b11 : bad ? 2'b10 : 2'b00;
                    ed = er == 0 ? ref_mem[off[5:2]] : 32'h0;
                    check("rand_data", data, ed);
                end
                check("rand_resp", resp, er);
                lv = lfsr_at(kh);
                check("rand_delay", dly, 32'(lv[2:0]));
                check("rand_delay_range", dly >= 0 && dly <= 7, 1);
                dlog[p][j] = dly;
            end
        end
        nd = 0;
        for (int j = 0; j < 216; j++) if (dlog[0][j] != dlog[1][j]) nd++;
        check("delay_replay_diffs", nd, 0);

        // reset while the write is counting down must abandon it
        txn(2, 1, 32'h8000_0040, 2, 32'h55555555, 4'hF, resp, data, dly, kh);
        @(posedge clk); #1;
        awaddr[2] = 32'h8000_0040; wdata[2] = 32'h99999999; wstrb[2] = 4'hF;
        awvalid[2] = 1; wvalid[2] = 1; bready[2] = 0;
        @(negedge clk);
        check("wrst_hs", {awready[2], wready[2]}, 2'b11);
        @(posedge clk); #1 awvalid[2] = 0; wvalid[2] = 0; rst = 0;
        @(negedge clk);
        check("wrst_forced_low", {arready[2], awready[2], wready[2]}, 0);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        check("wrst_bvalid", bvalid[2], 0);
        check("wrst_readies", {arready[2], awready[2], wready[2]}, 3'b111);
        txn(2, 0, 32'h8000_0040, 2, 0, 0, resp, data, dly, kh);
        check("wrst_mem_kept", data, 32'h55555555);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- AXI4-lite responder: the memory end of the load/store bus, answering the LSU's AR/R and AW/W/B traffic from an internal word-addressed SRAM array.
- Read and write channels run independent FSMs.
- Response latency is programmable: fixed, or pseudo-random from an LFSR, so the master's wait states are exercised.
- Used as the simulation/FPGA data memory behind the LSU.

Parameters:
- ADDR_BASE, 32'h8000_0000, first byte address decoded.
- DEPTH_WORDS, 4096, number of 32-bit words.
- RAND_DELAY, 1, 1 = latency from LFSR; 0 = FIXED_DELAY.
- FIXED_DELAY, 0, extra wait cycles when RAND_DELAY=0 (0..7).
- DELAY_BITS, 3, LFSR bits used as random delay (0..2^DELAY_BITS-1).
- LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- arsize  in  3  access size, 0=byte, 1=half, 2=word
- rdata  out  32  full aligned word, unshifted
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data, lane-aligned
- wstrb  in  4  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- Reset (rst=0 at a clk edge):
  - Read FSM goes to R_IDLE; write FSM goes to W_COLLECT; captured flags clear.
  - LFSR loads LFSR_SEED.
  - rvalid=bvalid=0, rdata=0, rresp=bresp=0.
  - arready/awready/wready are forced 0 while rst=0.
  - The array is not cleared.
  - Reset mid-transaction abandons it; no memory write unless the write has already entered W_RESP.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every cycle. D = RAND_DELAY ? lfsr[DELAY_BITS-1:0] : FIXED_DELAY, sampled at the handshake cycle.
- Decode:
  - in range iff ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS;
  - index = (addr - ADDR_BASE) >> 2.
- Read FSM (R_IDLE, R_WAIT, R_RESP):
  - R_IDLE: arready=1. On arvalid, latch araddr/arsize, load counter with D, go to R_WAIT.
  - R_WAIT: if counter==0, go to R_RESP, else decrement.
  - Timing: AR handshake in cycle N gives first rvalid in cycle N+2+D.
  - Entering R_RESP registers rdata/rresp from the array state before that edge.
  - Response coding:
    - out of range: rresp=11, rdata=0;
    - misaligned (arsize=1 and addr[0]=1, or arsize=2 and addr[1:0]!=0): rresp=10, rdata=0;
    - arsize>2: rresp=10;
    - otherwise: rresp=00, rdata=mem[index].
  - R_RESP: rvalid=1; rdata/rresp held stable until rready. On handshake go to R_IDLE; arready is 1 the next cycle.
- Write FSM (W_COLLECT, W_WAIT, W_RESP):
  - W_COLLECT: awready=!aw_got, wready=!w_got.
  - AW and W are captured independently, in either order or in the same cycle.
  - When both are held (including the capture cycle), load counter with D and go to W_WAIT.
  - W_WAIT: same countdown as the read side.
  - Entering W_RESP commits the write: if in range, byte lanes with wstrb[i]=1 are written.
  - Write responses:
    - wstrb=0: no change, OKAY;
    - out of range: no write, bresp=11;
    - in range: bresp=00. No size check on writes; wstrb is authoritative.
  - W_RESP: bvalid=1 until bready, then clear flags and go to W_COLLECT.
- Read/write interaction: the channels may overlap. If a read enters R_RESP in the same cycle a write enters W_RESP to the same word, the read returns the old data. A later read sees the new data.
- No outstanding-transaction queue: at most one read and one write in flight.

Test Plan:
- RAND_DELAY=0, FIXED_DELAY=0:
  - Write awaddr=8000_0010, wdata=DEADBEEF, wstrb=F, then read the same address with arsize=2 → bvalid 2 cycles after the handshake with bresp=00. rdata=DEADBEEF with rresp=00; rvalid rises 2 cycles after the AR handshake.
  - W presented 3 cycles before AW; then wstrb=0010 with wdata=0000_AA00 to 8000_0010 → wready drops after capture; bvalid only after AW arrives. Readback = DEADAAEF.
- FIXED_DELAY=5, rready held low 4 cycles → rvalid at N+7. rdata/rresp stable for all 4 stall cycles; arready=0 until the R handshake completes.
- Reads to 7FFF_FFFC and to 8000_4000 (DEPTH 4096) → rresp=11, rdata=0. A write to 8000_4000 gives bresp=11 with no array change.
- arsize=1 with araddr=8000_0001 → rresp=10; arsize=1 with araddr=8000_0002 → rresp=00, full word.
- RAND_DELAY=1: 200 random reads/writes against a scoreboard → all data matches, every delay lies within 0..7, and the delay sequence is identical after re-reset. Drop rst for one cycle during W_WAIT → no array change, bvalid=0, and the ready outputs return to 1.
